// File: rtl/edge_burst_detect_pkg.sv
// rtl/edge_burst_detect_pkg.sv - mode encoding and sizing helpers for edge_burst_detect
package edge_burst_pkg;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    // Width needed to hold every count 0..win, and therefore every threshold.
    function automatic int cnt_width(input int win);
        return $clog2(win + 1);
    endfunction

    function automatic logic edge_event(input logic cur, input logic old, input logic [1:0] mode);
        logic evt;
        case (mode_e'(mode))
            MODE_RISE: evt = cur & ~old;
            MODE_FALL: evt = ~cur & old;
            MODE_BOTH: evt = cur ^ old;
            MODE_OFF:  evt = 1'b0;
        endcase
        return evt;
    endfunction

endpackage

// File: rtl/ebd_channel.sv
// rtl/ebd_channel.sv - one channel: synchronizer, edge select, window ring buffer, hit and sticky
module ebd_channel
    import edge_burst_pkg::*;
#(
    parameter int WIN   = 5,
    parameter int CNT_W = 3,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_sig_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] thr_i,
    input  logic             clr_win_i,
    input  logic             clr_sticky_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             hit_o,
    output logic             hit_sticky_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic             s1_q;
    logic             s2_q;
    logic             prev_q;
    logic [WIN-1:0]   rb_q;
    logic [WIN-1:0]   rb_d;
    logic [CNT_W-1:0] sum_q;
    logic [CNT_W-1:0] sum_d;
    logic             cond_q;
    logic             cond_d;
    logic             hit_q;
    logic             hit_d;
    logic             sticky_q;
    logic             sticky_d;

    logic             evt;
    logic [CNT_W:0]   sum_next;
    logic             cond;

    always_comb begin
        evt = edge_event(s2_q, prev_q, mode_i);
        // One extra bit so the running sum can never wrap before the compare.
        sum_next = {1'b0, sum_q} - {{CNT_W{1'b0}}, rb_q[idx_i]} + {{CNT_W{1'b0}}, evt};
        cond     = (thr_i != '0) && (sum_next >= {1'b0, thr_i});

        rb_d        = rb_q;
        rb_d[idx_i] = evt;
        sum_d       = sum_next[CNT_W-1:0];
        cond_d      = cond;
        hit_d       = cond & ~cond_q;

        if (clr_win_i) begin
            rb_d   = '0;
            sum_d  = '0;
            cond_d = 1'b0;
            hit_d  = 1'b0;
        end

        // A new hit wins over a simultaneous clear.
        sticky_d = hit_d | (sticky_q & ~clr_sticky_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            rb_q     <= '0;
            sum_q    <= '0;
            cond_q   <= 1'b0;
            hit_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            s1_q     <= in_sig_i;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            rb_q     <= rb_d;
            sum_q    <= sum_d;
            cond_q   <= cond_d;
            hit_q    <= hit_d;
            sticky_q <= sticky_d;
        end
    end

    assign hit_o        = hit_q;
    assign hit_sticky_o = sticky_q;
    assign cnt_o        = sum_q;

endmodule

// File: rtl/edge_burst_detect.sv
// rtl/edge_burst_detect.sv - NCH-channel sliding-window edge burst detector with shared window index
module edge_burst_detect
    import edge_burst_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int WIN   = 5,
    localparam int CNT_W = cnt_width(WIN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_sig,
    input  logic [1:0]           mode,
    input  logic [CNT_W-1:0]     thr,
    input  logic                 clr_win,
    input  logic [NCH-1:0]       clr_sticky,
    output logic [NCH-1:0]       hit,
    output logic [NCH-1:0]       hit_sticky,
    output logic [NCH*CNT_W-1:0] cnt
);

    localparam int               IDX_W    = $clog2(WIN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // One index for all channels keeps every window aligned to the same cycles.
    always_comb begin
        if (clr_win || (idx_q == IDX_LAST)) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        ebd_channel #(
            .WIN   (WIN),
            .CNT_W (CNT_W),
            .IDX_W (IDX_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_sig_i     (in_sig[ch]),
            .mode_i       (mode),
            .thr_i        (thr),
            .clr_win_i    (clr_win),
            .clr_sticky_i (clr_sticky[ch]),
            .idx_i        (idx_q),
            .hit_o        (hit[ch]),
            .hit_sticky_o (hit_sticky[ch]),
            .cnt_o        (cnt[ch*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_burst_detect.sv
// tb/tb_edge_burst_detect.sv - self-checking bench for edge_burst_detect against a queue-based window model
module tb_edge_burst_detect;

    localparam int NCH   = 4;
    localparam int WIN   = 5;
    localparam int CNT_W = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       in_sig = '0;
    logic [1:0]           mode = 2'b00;
    logic [CNT_W-1:0]     thr = '0;
    logic                 clr_win = 1'b0;
    logic [NCH-1:0]       clr_sticky = '0;
    logic [NCH-1:0]       hit;
    logic [NCH-1:0]       hit_sticky;
    logic [NCH*CNT_W-1:0] cnt;

    edge_burst_detect #(.NCH(NCH), .WIN(WIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sig     (in_sig),
        .mode       (mode),
        .thr        (thr),
        .clr_win    (clr_win),
        .clr_sticky (clr_sticky),
        .hit        (hit),
        .hit_sticky (hit_sticky),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: raw input samples per edge, and the accepted event vectors of the current window.
    logic [NCH-1:0] m_in_q[$];
    logic [NCH-1:0] m_ev_q[$];
    logic [NCH-1:0] m_cond;
    logic [NCH-1:0] m_hit;
    logic [NCH-1:0] m_sticky;
    int             m_cnt[NCH];
    int             pulses[NCH];
    int             maxcnt[NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [NCH-1:0] model_event(input logic [NCH-1:0] cur, input logic [NCH-1:0] old,
                                                   input logic [1:0] md);
        case (md)
            2'b00:   return cur & ~old;
            2'b01:   return ~cur & old;
            2'b10:   return cur ^ old;
            default: return '0;
        endcase
    endfunction

    task automatic model_reset();
        m_in_q.delete();
        repeat (3) m_in_q.push_back('0);
        m_ev_q.delete();
        m_cond   = '0;
        m_hit    = '0;
        m_sticky = '0;
        for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    endtask

    task automatic clear_stats();
        for (int c = 0; c < NCH; c++) begin
            pulses[c] = 0;
            maxcnt[c] = 0;
        end
    endtask

    task automatic tick();
        logic [NCH-1:0]       ev;
        logic [NCH-1:0]       cond;
        logic [NCH*CNT_W-1:0] exp_cnt;
        int                   n;
        @(posedge clk);
        n  = m_in_q.size();
        // An input sampled two edges ago versus three edges ago forms this edge's event.
        ev = model_event(m_in_q[n-2], m_in_q[n-3], mode);
        if (clr_win) begin
            m_ev_q.delete();
            m_hit  = '0;
            m_cond = '0;
            for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
        end else begin
            m_ev_q.push_back(ev);
            if (m_ev_q.size() > WIN) void'(m_ev_q.pop_front());
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0;
                foreach (m_ev_q[j]) m_cnt[c] += int'(m_ev_q[j][c]);
                cond[c] = (thr != 0) && (m_cnt[c] >= int'(thr));
            end
            m_hit  = cond & ~m_cond;
            m_cond = cond;
        end
        m_sticky = m_hit | (m_sticky & ~clr_sticky);
        m_in_q.push_back(in_sig);
        if (m_in_q.size() > 4) void'(m_in_q.pop_front());
        #1;
        for (int c = 0; c < NCH; c++) exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        check("cnt", 32'(cnt), 32'(exp_cnt));
        check("hit", 32'(hit), 32'(m_hit));
        check("hit_sticky", 32'(hit_sticky), 32'(m_sticky));
        for (int c = 0; c < NCH; c++) begin
            pulses[c] += int'(hit[c]);
            if (int'(cnt[c*CNT_W +: CNT_W]) > maxcnt[c]) maxcnt[c] = int'(cnt[c*CNT_W +: CNT_W]);
        end
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_hit", 32'(hit | hit_sticky), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    task automatic flush();
        in_sig  = '0;
        repeat (4) tick();
        clr_win = 1'b1;
        tick();
        clr_win = 1'b0;
        clear_stats();
    endtask

    task automatic burst3_ch0();
        for (int i = 0; i < 6; i++) begin
            in_sig = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        clear_stats();
        @(posedge clk);
        #1;
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_hit", 32'(hit), 32'd0);
        check("reset_sticky", 32'(hit_sticky), 32'd0);
        rst_n = 1'b1;

        // Three rising edges two cycles apart on ch0.
        mode = 2'b00;
        thr  = 3'd3;
        burst3_ch0();
        in_sig = '0;
        tick();
        check("lat_hit0", 32'(hit[0]), 32'd1);
        repeat (7) tick();
        check("b3_pulses0", 32'(pulses[0]), 32'd1);
        check("b3_pulses_other", 32'(pulses[1] + pulses[2] + pulses[3]), 32'd0);
        check("b3_max0", 32'(maxcnt[0]), 32'd3);

        // Rising edges every third cycle on ch1 never reach three in the window.
        flush();
        for (int i = 0; i < 15; i++) begin
            in_sig = (i % 3 == 0) ? 4'b0010 : 4'b0000;
            tick();
        end
        in_sig = '0;
        repeat (6) tick();
        check("slow_pulses1", 32'(pulses[1]), 32'd0);
        check("slow_max1", 32'(maxcnt[1]), 32'd2);

        // Both-edges mode: a two-cycle pulse on ch2 gives two events and one hit.
        flush();
        mode = 2'b10;
        thr  = 3'd2;
        in_sig = 4'b0100;
        repeat (2) tick();
        in_sig = '0;
        repeat (8) tick();
        check("both_pulses2", 32'(pulses[2]), 32'd1);
        check("both_max2", 32'(maxcnt[2]), 32'd2);

        // Sticky: set, survive a clear that coincides with a new hit, then clear alone.
        flush();
        mode = 2'b00;
        thr  = 3'd3;
        burst3_ch0();
        in_sig = '0;
        repeat (8) tick();
        check("sticky_set", 32'(hit_sticky[0]), 32'd1);
        burst3_ch0();
        in_sig     = '0;
        clr_sticky = 4'b0001;
        tick();
        clr_sticky = '0;
        check("sticky_collide_hit", 32'(hit[0]), 32'd1);
        check("sticky_collide", 32'(hit_sticky[0]), 32'd1);
        repeat (3) tick();
        clr_sticky = 4'b0001;
        tick();
        clr_sticky = '0;
        check("sticky_cleared", 32'(hit_sticky[0]), 32'd0);

        // Mid-burst window flush, then a single further edge.
        flush();
        for (int i = 0; i < 5; i++) begin
            in_sig = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        check("mid_cnt_pre", 32'(cnt[CNT_W-1:0]), 32'd2);
        clr_win = 1'b1;
        tick();
        clr_win = 1'b0;
        check("clr_cnt", 32'(cnt), 32'd0);
        check("clr_hit", 32'(hit), 32'd0);
        in_sig = 4'b0001;
        tick();
        in_sig = '0;
        repeat (2) tick();
        check("clr_after_cnt", 32'(cnt[CNT_W-1:0]), 32'd1);
        check("clr_after_hit", 32'(hit[0]), 32'd0);

        // Mid-burst asynchronous reset, then a single further edge.
        flush();
        for (int i = 0; i < 5; i++) begin
            in_sig = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        check("rst_mid_cnt_pre", 32'(cnt[CNT_W-1:0]), 32'd2);
        pulse_reset();
        in_sig = 4'b0001;
        tick();
        in_sig = '0;
        repeat (2) tick();
        check("rst_after_cnt", 32'(cnt[CNT_W-1:0]), 32'd1);
        check("rst_after_hit", 32'(hit[0]), 32'd0);

        // thr=0 disables hits; thr=6 exceeds the window; count saturates at 5.
        flush();
        mode = 2'b10;
        thr  = 3'd0;
        for (int i = 0; i < 12; i++) begin
            in_sig = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        check("thr0_pulses", 32'(pulses[0]), 32'd0);
        check("thr0_cnt", 32'(cnt[CNT_W-1:0]), 32'd5);
        thr = 3'd6;
        for (int i = 0; i < 12; i++) begin
            in_sig = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        check("thr6_pulses", 32'(pulses[0]), 32'd0);
        check("thr6_max", 32'(maxcnt[0]), 32'd5);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                thr  = CNT_W'($urandom_range(0, 7));
                mode = 2'($urandom_range(0, 3));
            end
            in_sig     = NCH'($urandom);
            clr_win    = ($urandom_range(0, 19) == 0);
            clr_sticky = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
            tick();
            if (i % 97 == 50) pulse_reset();
        end
        clr_win    = 1'b0;
        clr_sticky = '0;
        in_sig     = '0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
